// File: rtl/axi_rr_arbiter_if.sv
// rtl/axi_rr_arbiter_if.sv - requester-side and downstream AXI signal bundle for axi_rr_arbiter
// Modport master is the arbiter's view (it drives the downstream port); slave is the environment's.
interface axi_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_LEN    = 32,
  parameter int DATA_LEN    = 32
);
  localparam int N  = NUM_MASTERS;
  localparam int SW = DATA_LEN / 8;

  logic [N-1:0]          m_ar_valid;
  logic [N-1:0]          m_ar_ready;
  logic [N*ADDR_LEN-1:0] m_ar_addr;
  logic [N*8-1:0]        m_ar_len;
  logic [N*3-1:0]        m_ar_size;
  logic [N-1:0]          m_r_valid;
  logic [N-1:0]          m_r_ready;
  logic [DATA_LEN-1:0]   m_r_data;
  logic [1:0]            m_r_resp;
  logic                  m_r_last;
  logic [N-1:0]          m_aw_valid;
  logic [N-1:0]          m_aw_ready;
  logic [N*ADDR_LEN-1:0] m_aw_addr;
  logic [N*3-1:0]        m_aw_size;
  logic [N-1:0]          m_w_valid;
  logic [N-1:0]          m_w_ready;
  logic [N*DATA_LEN-1:0] m_w_data;
  logic [N*SW-1:0]       m_w_strb;
  logic [N-1:0]          m_b_valid;
  logic [N-1:0]          m_b_ready;
  logic [1:0]            m_b_resp;

  logic                  s_ar_valid;
  logic                  s_ar_ready;
  logic [ADDR_LEN-1:0]   s_ar_addr;
  logic [3:0]            s_ar_id;
  logic [7:0]            s_ar_len;
  logic [2:0]            s_ar_size;
  logic [1:0]            s_ar_burst;
  logic                  s_r_valid;
  logic                  s_r_ready;
  logic [DATA_LEN-1:0]   s_r_data;
  logic [1:0]            s_r_resp;
  logic                  s_r_last;
  logic [3:0]            s_r_id;
  logic                  s_aw_valid;
  logic                  s_aw_ready;
  logic [ADDR_LEN-1:0]   s_aw_addr;
  logic [3:0]            s_aw_id;
  logic [7:0]            s_aw_len;
  logic [2:0]            s_aw_size;
  logic [1:0]            s_aw_burst;
  logic                  s_w_valid;
  logic                  s_w_ready;
  logic [DATA_LEN-1:0]   s_w_data;
  logic [SW-1:0]         s_w_strb;
  logic                  s_w_last;
  logic                  s_b_valid;
  logic                  s_b_ready;
  logic [1:0]            s_b_resp;
  logic [3:0]            s_b_id;

  modport master (
    input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_size, m_r_ready,
    input  m_aw_valid, m_aw_addr, m_aw_size, m_w_valid, m_w_data, m_w_strb, m_b_ready,
    output m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last,
    output m_aw_ready, m_w_ready, m_b_valid, m_b_resp,
    output s_ar_valid, s_ar_addr, s_ar_id, s_ar_len, s_ar_size, s_ar_burst, s_r_ready,
    output s_aw_valid, s_aw_addr, s_aw_id, s_aw_len, s_aw_size, s_aw_burst,
    output s_w_valid, s_w_data, s_w_strb, s_w_last, s_b_ready,
    input  s_ar_ready, s_r_valid, s_r_data, s_r_resp, s_r_last, s_r_id,
    input  s_aw_ready, s_w_ready, s_b_valid, s_b_resp, s_b_id
  );

  modport slave (
    output m_ar_valid, m_ar_addr, m_ar_len, m_ar_size, m_r_ready,
    output m_aw_valid, m_aw_addr, m_aw_size, m_w_valid, m_w_data, m_w_strb, m_b_ready,
    input  m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last,
    input  m_aw_ready, m_w_ready, m_b_valid, m_b_resp,
    input  s_ar_valid, s_ar_addr, s_ar_id, s_ar_len, s_ar_size, s_ar_burst, s_r_ready,
    input  s_aw_valid, s_aw_addr, s_aw_id, s_aw_len, s_aw_size, s_aw_burst,
    input  s_w_valid, s_w_data, s_w_strb, s_w_last, s_b_ready,
    output s_ar_ready, s_r_valid, s_r_data, s_r_resp, s_r_last, s_r_id,
    output s_aw_ready, s_w_ready, s_b_valid, s_b_resp, s_b_id
  );
endinterface

// File: rtl/axi_rr_arbiter.sv
// rtl/axi_rr_arbiter.sv - N-master AXI4 arbiter, one read burst or single-beat write per grant
// AXI_ARB_RR_EN selects round-robin; undefined gives fixed priority (highest index wins).
module axi_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_LEN    = 32,
  parameter int DATA_LEN    = 32
) (
  input  logic             clock,
  input  logic             reset,
  axi_rr_arbiter_if.master bus,
  output logic             id_err_o
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DATA_LEN / 8;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {IDLE, BUSY_RD, BUSY_WR} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       gnt, gnt_nxt;
  logic                ar_done, ar_done_nxt;
  logic                aw_done, aw_done_nxt;
  logic                w_done, w_done_nxt;
  logic                id_err_nxt;
  logic [3:0]          gnt_id;
  logic [NUM_MASTERS-1:0] wr_req, rd_req, req;
  logic [IW-1:0]       win;
  logic                win_found;
  logic                r_hs, b_hs;
`ifdef AXI_ARB_RR_EN
  logic [IW-1:0]       last_gnt, last_gnt_nxt;
`endif

  logic [ADDR_LEN-1:0] ar_addr_a [NUM_MASTERS];
  logic [7:0]          ar_len_a  [NUM_MASTERS];
  logic [2:0]          ar_size_a [NUM_MASTERS];
  logic [ADDR_LEN-1:0] aw_addr_a [NUM_MASTERS];
  logic [2:0]          aw_size_a [NUM_MASTERS];
  logic [DATA_LEN-1:0] w_data_a  [NUM_MASTERS];
  logic [SW-1:0]       w_strb_a  [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign ar_addr_a[i] = bus.m_ar_addr[i*ADDR_LEN +: ADDR_LEN];
    assign ar_len_a[i]  = bus.m_ar_len[i*8 +: 8];
    assign ar_size_a[i] = bus.m_ar_size[i*3 +: 3];
    assign aw_addr_a[i] = bus.m_aw_addr[i*ADDR_LEN +: ADDR_LEN];
    assign aw_size_a[i] = bus.m_aw_size[i*3 +: 3];
    assign w_data_a[i]  = bus.m_w_data[i*DATA_LEN +: DATA_LEN];
    assign w_strb_a[i]  = bus.m_w_strb[i*SW +: SW];
  end

  // A write request needs both AW and W presented; it outranks a read from the same master.
  assign wr_req = bus.m_aw_valid & bus.m_w_valid;
  assign rd_req = bus.m_ar_valid;
  assign req    = wr_req | rd_req;
  assign gnt_id = 4'(gnt);
  assign r_hs   = bus.s_r_valid & bus.s_r_ready;
  assign b_hs   = bus.s_b_valid & bus.s_b_ready;

  always_comb begin
    win       = '0;
    win_found = 1'b0;
`ifdef AXI_ARB_RR_EN
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!win_found && req[IW'((int'(last_gnt) + k) % NUM_MASTERS)]) begin
        win       = IW'((int'(last_gnt) + k) % NUM_MASTERS);
        win_found = 1'b1;
      end
    end
`else
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (req[IW'(i)]) begin
        win       = IW'(i);
        win_found = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      ar_done  <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      id_err_o <= 1'b0;
`ifdef AXI_ARB_RR_EN
      last_gnt <= IW'(NUM_MASTERS - 1);
`endif
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      ar_done  <= ar_done_nxt;
      aw_done  <= aw_done_nxt;
      w_done   <= w_done_nxt;
      id_err_o <= id_err_nxt;
`ifdef AXI_ARB_RR_EN
      last_gnt <= last_gnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    ar_done_nxt = ar_done | (bus.s_ar_valid & bus.s_ar_ready);
    aw_done_nxt = aw_done | (bus.s_aw_valid & bus.s_aw_ready);
    w_done_nxt  = w_done  | (bus.s_w_valid & bus.s_w_ready);
    id_err_nxt  = id_err_o;
`ifdef AXI_ARB_RR_EN
    last_gnt_nxt = last_gnt;
`endif
    if (r_hs && (bus.s_r_id != gnt_id)) id_err_nxt = 1'b1;
    if (b_hs && (bus.s_b_id != gnt_id)) id_err_nxt = 1'b1;
    case (state)
      IDLE: begin
        if (win_found) begin
          gnt_nxt   = win;
          state_nxt = wr_req[win] ? BUSY_WR : BUSY_RD;
`ifdef AXI_ARB_RR_EN
          last_gnt_nxt = win;
`endif
        end
      end
      BUSY_RD: if (r_hs && bus.s_r_last) state_nxt = IDLE;
      BUSY_WR: if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == IDLE) begin
      ar_done_nxt = 1'b0;
      aw_done_nxt = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  always_comb begin
    bus.m_ar_ready = '0;
    bus.m_r_valid  = '0;
    bus.m_r_data   = '0;
    bus.m_r_resp   = '0;
    bus.m_r_last   = 1'b0;
    bus.m_aw_ready = '0;
    bus.m_w_ready  = '0;
    bus.m_b_valid  = '0;
    bus.m_b_resp   = '0;
    bus.s_ar_valid = 1'b0;
    bus.s_ar_addr  = '0;
    bus.s_ar_id    = '0;
    bus.s_ar_len   = '0;
    bus.s_ar_size  = '0;
    bus.s_ar_burst = '0;
    bus.s_r_ready  = 1'b0;
    bus.s_aw_valid = 1'b0;
    bus.s_aw_addr  = '0;
    bus.s_aw_id    = '0;
    bus.s_aw_len   = '0;
    bus.s_aw_size  = '0;
    bus.s_aw_burst = '0;
    bus.s_w_valid  = 1'b0;
    bus.s_w_data   = '0;
    bus.s_w_strb   = '0;
    bus.s_w_last   = 1'b0;
    bus.s_b_ready  = 1'b0;
    case (state)
      BUSY_RD: begin
        if (!ar_done) begin
          bus.s_ar_valid      = bus.m_ar_valid[gnt];
          bus.s_ar_addr       = ar_addr_a[gnt];
          bus.s_ar_id         = gnt_id;
          bus.s_ar_len        = ar_len_a[gnt];
          bus.s_ar_size       = ar_size_a[gnt];
          bus.s_ar_burst      = BURST_INCR;
          bus.m_ar_ready[gnt] = bus.s_ar_ready;
        end
        // Responses are routed even before AR completes; the slave may answer early.
        bus.m_r_valid[gnt] = bus.s_r_valid;
        bus.s_r_ready      = bus.m_r_ready[gnt];
        bus.m_r_data       = bus.s_r_data;
        bus.m_r_resp       = bus.s_r_resp;
        bus.m_r_last       = bus.s_r_last;
      end
      BUSY_WR: begin
        if (!aw_done) begin
          bus.s_aw_valid      = bus.m_aw_valid[gnt];
          bus.s_aw_addr       = aw_addr_a[gnt];
          bus.s_aw_id         = gnt_id;
          bus.s_aw_size       = aw_size_a[gnt];
          bus.s_aw_burst      = BURST_FIXED;
          bus.m_aw_ready[gnt] = bus.s_aw_ready;
        end
        if (!w_done) begin
          bus.s_w_valid      = bus.m_w_valid[gnt];
          bus.s_w_data       = w_data_a[gnt];
          bus.s_w_strb       = w_strb_a[gnt];
          bus.s_w_last       = 1'b1;
          bus.m_w_ready[gnt] = bus.s_w_ready;
        end
        bus.m_b_valid[gnt] = bus.s_b_valid;
        bus.s_b_ready      = bus.m_b_ready[gnt];
        bus.m_b_resp       = bus.s_b_resp;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb/tb_axi_rr_arbiter.sv - table-driven scoreboard bench for axi_rr_arbiter (two masters)
`timescale 1ns/1ps
module tb_axi_rr_arbiter;
  localparam int N = 2;
  localparam int A = 32;
  localparam int D = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic id_err;

  axi_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_LEN(A), .DATA_LEN(D)) bus ();

  axi_rr_arbiter #(.NUM_MASTERS(N), .ADDR_LEN(A), .DATA_LEN(D)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .id_err_o (id_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          mi;
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [3:0]  rid;
    logic [3:0]  exp_id;
    logic [7:0]  exp_len;
    logic [1:0]  exp_burst;
  } vec_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] beat_q[$];
  vec_t        vecs[4];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(bit mi);
    return mi ? 2'b10 : 2'b01;
  endfunction

  task automatic idle_inputs();
    bus.m_ar_valid = '0; bus.m_ar_addr = '0; bus.m_ar_len = '0; bus.m_ar_size = {3'd2, 3'd2};
    bus.m_r_ready  = '0; bus.m_aw_valid = '0; bus.m_aw_addr = '0; bus.m_aw_size = {3'd2, 3'd2};
    bus.m_w_valid  = '0; bus.m_w_data = '0; bus.m_w_strb = '0; bus.m_b_ready = '0;
    bus.s_ar_ready = 1'b0; bus.s_r_valid = 1'b0; bus.s_r_data = '0; bus.s_r_resp = '0;
    bus.s_r_last   = 1'b0; bus.s_r_id = '0; bus.s_aw_ready = 1'b0; bus.s_w_ready = 1'b0;
    bus.s_b_valid  = 1'b0; bus.s_b_resp = '0; bus.s_b_id = '0;
  endtask

  task automatic drive_ar(bit mi, logic [31:0] addr, logic [7:0] len);
    bus.m_ar_valid[mi] = 1'b1;
    if (mi) begin bus.m_ar_addr[63:32] = addr; bus.m_ar_len[15:8] = len; end
    else    begin bus.m_ar_addr[31:0]  = addr; bus.m_ar_len[7:0]  = len; end
  endtask

  task automatic drive_wr(bit mi, logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
    bus.m_aw_valid[mi] = 1'b1;
    bus.m_w_valid[mi]  = 1'b1;
    if (mi) begin bus.m_aw_addr[63:32] = addr; bus.m_w_data[63:32] = data; bus.m_w_strb[7:4] = strb; end
    else    begin bus.m_aw_addr[31:0]  = addr; bus.m_w_data[31:0]  = data; bus.m_w_strb[3:0] = strb; end
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_read(vec_t v);
    exp_t e;
    @(negedge clock);
    drive_ar(v.mi, v.addr, v.len);
    sb_q.push_back('{id: v.exp_id, addr: v.addr, len: v.exp_len, burst: v.exp_burst, data: '0, strb: '0});
    @(negedge clock);
    bus.s_ar_ready = 1'b1;
    #1;
    e = sb_q.pop_front();
    chk("ar_valid", bus.s_ar_valid, 1);
    chk("ar_id", bus.s_ar_id, e.id);
    chk("ar_addr", bus.s_ar_addr, e.addr);
    chk("ar_len", bus.s_ar_len, e.len);
    chk("ar_burst", bus.s_ar_burst, e.burst);
    chk("ar_ready_route", bus.m_ar_ready, onehot(v.mi));
    @(negedge clock);
    bus.s_ar_ready = 1'b0;
    bus.m_ar_valid[v.mi] = 1'b0;
    #1 chk("ar_done", bus.s_ar_valid, 0);
    for (int b = 0; b <= int'(v.len); b++) begin
      bus.s_r_valid = 1'b1;
      bus.s_r_data  = $urandom;
      bus.s_r_last  = (b == int'(v.len));
      bus.s_r_id    = v.rid;
      bus.s_r_resp  = v.resp;
      bus.m_r_ready[v.mi] = 1'b1;
      beat_q.push_back(bus.s_r_data);
      #1;
      chk("r_valid_route", bus.m_r_valid, onehot(v.mi));
      chk("r_data", bus.m_r_data, beat_q.pop_front());
      chk("r_last", bus.m_r_last, (b == int'(v.len)));
      @(negedge clock);
    end
    bus.s_r_valid = 1'b0;
    bus.s_r_last  = 1'b0;
    bus.m_r_ready = '0;
    #1 chk("r_idle", {bus.m_r_valid, bus.s_r_ready}, 0);
  endtask

  task automatic run_write(vec_t v);
    exp_t e;
    @(negedge clock);
    drive_wr(v.mi, v.addr, v.data, v.strb);
    sb_q.push_back('{id: v.exp_id, addr: v.addr, len: v.exp_len, burst: v.exp_burst, data: v.data, strb: v.strb});
    @(negedge clock);
    bus.s_aw_ready = 1'b1;
    bus.s_w_ready  = 1'b1;
    #1;
    e = sb_q.pop_front();
    chk("aw_valid", {bus.s_aw_valid, bus.s_w_valid}, 2'b11);
    chk("aw_id", bus.s_aw_id, e.id);
    chk("aw_addr", bus.s_aw_addr, e.addr);
    chk("aw_len", bus.s_aw_len, e.len);
    chk("aw_burst", bus.s_aw_burst, e.burst);
    chk("w_data", bus.s_w_data, e.data);
    chk("w_strb", bus.s_w_strb, e.strb);
    chk("w_last", bus.s_w_last, 1);
    chk("aw_w_ready_route", {bus.m_aw_ready, bus.m_w_ready}, {onehot(v.mi), onehot(v.mi)});
    @(negedge clock);
    bus.m_aw_valid = '0; bus.m_w_valid = '0;
    bus.s_aw_ready = 1'b0; bus.s_w_ready = 1'b0;
    bus.s_b_valid = 1'b1; bus.s_b_resp = v.resp; bus.s_b_id = v.rid;
    bus.m_b_ready[v.mi] = 1'b1;
    #1;
    chk("aw_done", {bus.s_aw_valid, bus.s_w_valid}, 0);
    chk("b_valid_route", bus.m_b_valid, onehot(v.mi));
    chk("b_resp", bus.m_b_resp, v.resp);
    @(negedge clock);
    bus.s_b_valid = 1'b0;
    bus.m_b_ready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] cont_exp[4];
    logic [3:0] rst_exp;
    vec_t       v;

    vecs[0] = '{mi: 1'b0, wr: 1'b0, addr: 32'h8000_0000, len: 8'd3, data: '0, strb: '0, resp: 2'd0,
                rid: 4'd0, exp_id: 4'd0, exp_len: 8'd3, exp_burst: 2'b01};
    vecs[1] = '{mi: 1'b1, wr: 1'b1, addr: 32'h0200_0000, len: 8'd0, data: 32'hDEAD_BEEF, strb: 4'hF,
                resp: 2'd0, rid: 4'd1, exp_id: 4'd1, exp_len: 8'd0, exp_burst: 2'b00};
    vecs[2] = '{mi: 1'b1, wr: 1'b0, addr: 32'h1000_0040, len: 8'd0, data: '0, strb: '0, resp: 2'd0,
                rid: 4'd1, exp_id: 4'd1, exp_len: 8'd0, exp_burst: 2'b01};
    vecs[3] = '{mi: 1'b0, wr: 1'b1, addr: 32'h0000_1000, len: 8'd0, data: 32'h1234_5678, strb: 4'h3,
                resp: 2'd2, rid: 4'd0, exp_id: 4'd0, exp_len: 8'd0, exp_burst: 2'b00};
`ifdef AXI_ARB_RR_EN
    cont_exp = '{4'd0, 4'd1, 4'd0, 4'd1};
    rst_exp  = 4'd0;
`else
    cont_exp = '{4'd1, 4'd1, 4'd1, 4'd1};
    rst_exp  = 4'd1;
`endif

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_outputs", {bus.s_ar_valid, bus.s_aw_valid, bus.s_w_valid, bus.s_r_ready, bus.s_b_ready,
                          bus.m_ar_ready, bus.m_r_valid, bus.m_aw_ready, bus.m_w_ready, bus.m_b_valid}, 0);
    chk("reset_id_err", id_err, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].wr) run_write(vecs[i]);
      else            run_read(vecs[i]);
    end
    chk("id_err_clean", id_err, 0);

    // Both masters request reads continuously; each grant is followed by one idle cycle.
    do_reset();
    @(negedge clock);
    drive_ar(1'b0, 32'h0000_0100, 8'd0);
    drive_ar(1'b1, 32'h0000_0200, 8'd0);
    bus.m_r_ready = 2'b11;
    for (int g = 0; g < 4; g++) begin
      @(negedge clock);
      #1;
      chk("cont_valid", bus.s_ar_valid, 1);
      chk("cont_gnt", bus.s_ar_id, cont_exp[g]);
      bus.s_ar_ready = 1'b1;
      bus.s_r_valid  = 1'b1;
      bus.s_r_last   = 1'b1;
      bus.s_r_id     = cont_exp[g];
      @(negedge clock);
      bus.s_ar_ready = 1'b0;
      bus.s_r_valid  = 1'b0;
      bus.s_r_last   = 1'b0;
      #1 chk("cont_idle_gap", bus.s_ar_valid, 0);
    end
    idle_inputs();

    // Master 1 holds a write and a read together: write first, read on the next arbitration.
    @(negedge clock);
    drive_wr(1'b1, 32'h0300_0000, 32'hCAFE_F00D, 4'hF);
    drive_ar(1'b1, 32'h0300_0010, 8'd0);
    @(negedge clock);
    #1;
    chk("wr_first_aw", {bus.s_aw_valid, bus.s_aw_id}, {1'b1, 4'd1});
    chk("wr_first_no_ar", bus.s_ar_valid, 0);
    bus.s_aw_ready = 1'b1; bus.s_w_ready = 1'b1;
    @(negedge clock);
    bus.m_aw_valid = '0; bus.m_w_valid = '0;
    bus.s_aw_ready = 1'b0; bus.s_w_ready = 1'b0;
    bus.s_b_valid = 1'b1; bus.s_b_id = 4'd1; bus.m_b_ready = 2'b10;
    @(negedge clock);
    bus.s_b_valid = 1'b0; bus.m_b_ready = '0;
    #1 chk("wr_then_idle", bus.s_ar_valid, 0);
    @(negedge clock);
    #1 chk("rd_after_wr", {bus.s_ar_valid, bus.s_ar_id}, {1'b1, 4'd1});
    bus.s_ar_ready = 1'b1; bus.s_r_valid = 1'b1; bus.s_r_last = 1'b1; bus.s_r_id = 4'd1;
    bus.m_r_ready = 2'b10;
    @(negedge clock);
    idle_inputs();

    // Wrong response ID raises the sticky error until reset.
    chk("id_err_before", id_err, 0);
    v = '{mi: 1'b0, wr: 1'b0, addr: 32'h4000_0000, len: 8'd0, data: '0, strb: '0, resp: 2'd0,
          rid: 4'd3, exp_id: 4'd0, exp_len: 8'd0, exp_burst: 2'b01};
    run_read(v);
    chk("id_err_set", id_err, 1);
    run_write(vecs[1]);
    chk("id_err_sticky", id_err, 1);
    do_reset();
    chk("id_err_reset", id_err, 0);

    // Asynchronous reset in the middle of a four-beat burst.
    @(negedge clock);
    drive_ar(1'b0, 32'h8000_0000, 8'd3);
    @(negedge clock);
    bus.s_ar_ready = 1'b1;
    @(negedge clock);
    bus.s_ar_ready = 1'b0; bus.m_ar_valid = '0;
    bus.s_r_valid = 1'b1; bus.s_r_id = 4'd0; bus.m_r_ready = 2'b01;
    @(negedge clock);
    #1 chk("mid_burst_routed", bus.m_r_valid, 2'b01);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", {bus.m_r_valid, bus.s_r_ready, bus.s_ar_valid, bus.m_ar_ready,
                                bus.s_aw_valid, bus.s_w_valid, bus.m_b_valid, bus.s_b_ready}, 0);
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    @(negedge clock);
    drive_ar(1'b0, 32'h0000_0500, 8'd0);
    drive_ar(1'b1, 32'h0000_0600, 8'd0);
    @(negedge clock);
    #1 chk("post_reset_gnt", {bus.s_ar_valid, bus.s_ar_id}, {1'b1, rst_exp});
    bus.s_ar_ready = 1'b1; bus.s_r_valid = 1'b1; bus.s_r_last = 1'b1; bus.s_r_id = rst_exp;
    bus.m_r_ready = 2'b11;
    @(negedge clock);
    idle_inputs();
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
